bg_frame_capture: RTL and testbench

//  Writer side of the 320x240 RGB565 background frame store that the chroma-key stage reads.
//  On request, grabs one 640x480 RGB444 camera frame and 2:1 decimates it in x and y.

---
 rtl/bg_frame_capture_if.sv | 28 ++
 rtl/bg_frame_capture.sv | 136 +++++++++++++
 tb/tb_bg_frame_capture.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/bg_frame_capture_if.sv
// Camera-in / frame-buffer-write bundle for the background frame capture block.
interface bg_frame_capture_if #(
  parameter int ADDR_W = 17
);
  logic              i_capture_req;
  logic              i_valid;
  logic              i_sof;
  logic              i_eol;
  logic [3:0]        i_red;
  logic [3:0]        i_green;
  logic [3:0]        i_blue;
  logic              o_we;
  logic [ADDR_W-1:0] o_waddr;
  logic [15:0]       o_wdata;
  logic              o_busy;
  logic              o_done;
  logic              o_frame_err;

  modport master (
    output i_capture_req, i_valid, i_sof, i_eol, i_red, i_green, i_blue,
    input  o_we, o_waddr, o_wdata, o_busy, o_done, o_frame_err
  );

  modport slave (
    input  i_capture_req, i_valid, i_sof, i_eol, i_red, i_green, i_blue,
    output o_we, o_waddr, o_wdata, o_busy, o_done, o_frame_err
  );
endinterface

// File: rtl/bg_frame_capture.sv
// Grabs one RGB444 camera frame on request, 2:1 decimates it and writes it
// bottom-row-first as RGB565 into the chroma-key background frame store.
module bg_frame_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int OUT_W    = 320,
  parameter int OUT_H    = 240,
  parameter int ADDR_W   = 17
) (
  input  logic               clk,
  input  logic               reset,
  bg_frame_capture_if.slave  bus
);
  localparam int X_W = $clog2(H_ACTIVE + 1);
  localparam int Y_W = $clog2(V_ACTIVE);
  localparam int R_W = $clog2(OUT_H);
  // OUT_W is a sum of two powers of two (320 = 256 + 64), so the row offset is two shifts.
  localparam int SH_HI = $clog2(OUT_W) - 1;
  localparam int SH_LO = $clog2(OUT_W - (1 << SH_HI));
  localparam logic [X_W-1:0] X_MAX    = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] Y_MAX    = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_ACTIVE - 1);
  localparam logic [R_W-1:0] ROW_LAST = R_W'(OUT_H - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t            state_r;
  logic [X_W-1:0]    x_r;
  logic [Y_W-1:0]    y_r;

  logic              accept_s;
  logic              restart_s;
  logic              wr_s;
  logic              last_line_s;
  logic [X_W-1:0]    px_x_s;
  logic [Y_W-1:0]    px_y_s;
  logic [R_W-1:0]    row_s;
  logic [ADDR_W-1:0] addr_s;
  logic [15:0]       rgb565_s;

  // Pixel acceptance, effective coordinates (sof forces 0,0), write address and colour.
  always_comb begin
    accept_s  = 1'b0;
    restart_s = 1'b0;
    case (state_r)
      ARM: begin
        accept_s  = bus.i_valid & bus.i_sof;
        restart_s = bus.i_valid & bus.i_sof;
      end
      CAPTURE: begin
        accept_s  = bus.i_valid;
        restart_s = bus.i_valid & bus.i_sof;
      end
      default: begin
        accept_s  = 1'b0;
        restart_s = 1'b0;
      end
    endcase

    if (restart_s) begin
      px_x_s = '0;
      px_y_s = '0;
    end else begin
      px_x_s = x_r;
      px_y_s = y_r;
    end

    wr_s        = accept_s & ~px_x_s[0] & ~px_y_s[0] & (px_x_s < X_MAX) & (px_y_s < Y_MAX);
    last_line_s = (px_y_s == Y_LAST);
    row_s       = ROW_LAST - R_W'(px_y_s >> 1);
    addr_s      = (ADDR_W'(row_s) << SH_HI) + (ADDR_W'(row_s) << SH_LO) + ADDR_W'(px_x_s >> 1);
    rgb565_s    = {bus.i_red, bus.i_red[3], bus.i_green, bus.i_green[3:2],
                   bus.i_blue, bus.i_blue[3]};
  end

  // Capture FSM, x/y counters and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= IDLE;
      x_r             <= '0;
      y_r             <= '0;
      bus.o_we        <= 1'b0;
      bus.o_waddr     <= '0;
      bus.o_wdata     <= 16'h0000;
      bus.o_busy      <= 1'b0;
      bus.o_done      <= 1'b0;
      bus.o_frame_err <= 1'b0;
    end else begin
      bus.o_we        <= wr_s;
      bus.o_done      <= 1'b0;
      bus.o_frame_err <= (state_r == CAPTURE) && restart_s;
      if (wr_s) begin
        bus.o_waddr <= addr_s;
        bus.o_wdata <= rgb565_s;
      end
      case (state_r)
        IDLE: begin
          if (bus.i_capture_req) begin
            state_r    <= ARM;
            bus.o_busy <= 1'b1;
          end
        end
        ARM, CAPTURE: begin
          if (accept_s) begin
            if (bus.i_eol) begin
              x_r <= '0;
              if (last_line_s) begin
                state_r    <= IDLE;
                y_r        <= '0;
                bus.o_done <= 1'b1;
                bus.o_busy <= 1'b0;
              end else begin
                state_r <= CAPTURE;
                y_r     <= px_y_s + Y_W'(1);
              end
            end else begin
              state_r <= CAPTURE;
              x_r     <= (px_x_s == X_MAX) ? X_MAX : px_x_s + X_W'(1);
              y_r     <= px_y_s;
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          x_r        <= '0;
          y_r        <= '0;
          bus.o_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bg_frame_capture.sv
// Randomized bench for bg_frame_capture with a behavioural reference model.
module tb_bg_frame_capture;
  logic clk = 1'b0;
  logic reset = 1'b1;

  bg_frame_capture_if #(.ADDR_W(17)) bus();

  bg_frame_capture dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: mode 0 = idle, 1 = waiting for sof, 2 = capturing.
  int m_mode = 0;
  int m_x = 0;
  int m_y = 0;
  int m_wr = 0;
  int e_addr = 0;
  int e_data = 0;
  bit e_we = 1'b0;
  bit e_busy = 1'b0;
  bit e_done = 1'b0;
  bit e_err = 1'b0;

  always @(posedge clk or posedge reset) begin
    int r, g, b;
    if (reset) begin
      m_mode = 0; m_x = 0; m_y = 0;
      e_addr = 0; e_data = 0;
      e_we = 0; e_busy = 0; e_done = 0; e_err = 0;
    end else begin
      e_we = 0; e_done = 0; e_err = 0;
      if (m_mode == 0) begin
        if (bus.i_capture_req) m_mode = 1;
      end else if (bus.i_valid && (m_mode == 2 || bus.i_sof)) begin
        if (bus.i_sof) begin
          if (m_mode == 2) e_err = 1;
          m_x = 0; m_y = 0; m_mode = 2;
        end
        if (m_x % 2 == 0 && m_y % 2 == 0 && m_x < 640 && m_y < 480) begin
          r = bus.i_red; g = bus.i_green; b = bus.i_blue;
          e_we = 1;
          m_wr++;
          e_addr = 320 * (239 - m_y / 2) + m_x / 2;
          e_data = (r * 2 + r / 8) * 2048 + (g * 4 + g / 4) * 32 + (b * 2 + b / 8);
        end
        if (bus.i_eol) begin
          if (m_y == 479) begin
            e_done = 1; m_mode = 0; m_x = 0; m_y = 0;
          end else begin
            m_x = 0; m_y++;
          end
        end else if (m_x < 640) begin
          m_x++;
        end
      end
      e_busy = (m_mode != 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Observation of DUT writes for the literal checks.
  bit checking = 1'b0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  bit err_arm = 1'b0;
  int addr_after_err = -1;
  logic [15:0] mem [0:76799];

  always @(negedge clk) begin
    if (checking) begin
      chk("we", 32'(bus.o_we), 32'(e_we));
      chk("busy", 32'(bus.o_busy), 32'(e_busy));
      chk("done", 32'(bus.o_done), 32'(e_done));
      chk("frame_err", 32'(bus.o_frame_err), 32'(e_err));
      chk("waddr", 32'(bus.o_waddr), 32'(e_addr));
      chk("wdata", 32'(bus.o_wdata), 32'(e_data));
      if (bus.o_frame_err) begin err_cnt++; err_arm = 1'b1; end
      if (bus.o_we) begin
        wr_cnt++;
        if (bus.o_waddr < 17'd76800) mem[bus.o_waddr] = bus.o_wdata;
        if (err_arm) begin addr_after_err = int'(bus.o_waddr); err_arm = 1'b0; end
      end
      if (bus.o_done) done_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic px(input bit sof, input bit eol, input logic [11:0] rgb, input bit req);
    while ($urandom_range(0, 3) == 0) begin
      bus.i_valid = 1'b0; bus.i_sof = 1'($urandom); bus.i_eol = 1'($urandom);
      bus.i_capture_req = 1'b0;
      cyc();
    end
    bus.i_valid = 1'b1; bus.i_sof = sof; bus.i_eol = eol; bus.i_capture_req = req;
    {bus.i_red, bus.i_green, bus.i_blue} = rgb;
    cyc();
    bus.i_valid = 1'b0; bus.i_sof = 1'b0; bus.i_eol = 1'b0; bus.i_capture_req = 1'b0;
  endtask

  function automatic logic [11:0] colour(input int x, input int y);
    if (x == 0 && y == 0) return 12'hF00;
    if (x == 2 && y == 0) return 12'hA53;
    if ((x == 0 && y == 2) || (x == 638 && y == 478)) return 12'hFFF;
    return 12'($urandom);
  endfunction

  function automatic int line_len(input int y);
    case (y)
      0, 478:  return 640;
      100:     return 700;
      2:       return 100;
      default: return $urandom_range(1, 24);
    endcase
  endfunction

  task automatic send_line(input int y, input int len, input bit eol_on, input bit req_last);
    for (int x = 0; x < len; x++)
      px(y == 0 && x == 0, eol_on && x == len - 1, colour(x, y), req_last && x == len - 1);
  endtask

  task automatic send_frame(input int y0, input int y1, input bit req_last);
    for (int y = y0; y < y1; y++) send_line(y, line_len(y), 1'b1, req_last && y == 479);
  endtask

  task automatic req();
    bus.i_capture_req = 1'b1;
    cyc();
    bus.i_capture_req = 1'b0;
  endtask

  task automatic clear_counts();
    wr_cnt = 0; done_cnt = 0; err_cnt = 0; m_wr = 0; addr_after_err = -1; err_arm = 1'b0;
  endtask

  initial begin
    bus.i_capture_req = 1'b0; bus.i_valid = 1'b0; bus.i_sof = 1'b0; bus.i_eol = 1'b0;
    bus.i_red = 4'h0; bus.i_green = 4'h0; bus.i_blue = 4'h0;
    cyc();
    checking = 1'b1;
    cyc();
    chk("rst_we", 32'(bus.o_we), 32'd0);
    chk("rst_waddr", 32'(bus.o_waddr), 32'd0);
    chk("rst_wdata", 32'(bus.o_wdata), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    reset = 1'b0;
    cyc();

    // sof-led lines with no request outstanding
    clear_counts();
    send_frame(0, 3, 1'b0);
    cyc();
    chk("no_req_writes", 32'(wr_cnt), 32'd0);

    // full frame with a request in the middle and another on the final eol
    clear_counts();
    req();
    send_frame(0, 200, 1'b0);
    req();
    send_frame(200, 480, 1'b1);
    cyc(); cyc(); cyc();
    chk("frame_done_cnt", 32'(done_cnt), 32'd1);
    chk("frame_wr_cnt", 32'(wr_cnt), 32'(m_wr));
    chk("px00_addr76480", 32'(mem[76480]), 32'h0000F800);
    chk("px20_addr76481", 32'(mem[76481]), 32'h0000AAA6);
    chk("px02_addr76160", 32'(mem[76160]), 32'h0000FFFF);
    chk("px638_478_addr319", 32'(mem[319]), 32'h0000FFFF);
    chk("idle_after_done", 32'(bus.o_busy), 32'd0);

    // sof arriving on line 100 restarts the frame
    clear_counts();
    req();
    send_frame(0, 100, 1'b0);
    send_line(100, 10, 1'b0, 1'b0);
    send_frame(0, 480, 1'b0);
    cyc(); cyc();
    chk("restart_err_cnt", 32'(err_cnt), 32'd1);
    chk("restart_first_addr", 32'(addr_after_err), 32'd76480);
    chk("restart_done_cnt", 32'(done_cnt), 32'd1);

    // reset in the middle of a capture
    clear_counts();
    req();
    send_frame(0, 6, 1'b0);
    send_line(6, 5, 1'b0, 1'b0);
    reset = 1'b1;
    cyc();
    chk("midrst_we", 32'(bus.o_we), 32'd0);
    chk("midrst_busy", 32'(bus.o_busy), 32'd0);
    chk("midrst_done", 32'(bus.o_done), 32'd0);
    cyc();
    reset = 1'b0;
    cyc();
    wr_cnt = 0;
    send_frame(0, 4, 1'b0);
    cyc();
    chk("after_rst_writes", 32'(wr_cnt), 32'd0);
    chk("after_rst_busy", 32'(bus.o_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
